// File: rtl/namuru_wb_csr.sv
// rtl/namuru_wb_csr.sv - Wishbone register bank for the Namuru correlator channels
// Byte-lane writes, programmable ack wait states, sticky dump flags with maskable interrupt.
module namuru_wb_csr #(
    parameter int          CHANNELS    = 12,
    parameter int          REGS_LOG2   = 3,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h4E410000
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic [31:0]                          wb_adr_i,
    input  logic [31:0]                          wb_dat_i,
    output logic [31:0]                          wb_dat_o,
    input  logic [3:0]                           wb_sel_i,
    input  logic                                 wb_stb_i,
    input  logic                                 wb_cyc_i,
    input  logic                                 wb_we_i,
    output logic                                 wb_ack_o,
    input  logic [CHANNELS-1:0]                  dump_strobe,
    output logic [CHANNELS*(2**REGS_LOG2)*32-1:0] ch_regs,
    output logic                                 accum_int
);
    localparam int         NREGS = CHANNELS * (2**REGS_LOG2);
    localparam int         IW    = $clog2(NREGS);
    localparam logic [7:0] CH8   = 8'(CHANNELS);
    localparam logic [7:0] NR8   = 8'(2**REGS_LOG2);
    localparam logic [3:0] WS4   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [11:0]         adr_q;
    logic [31:0]         dat_q;
    logic [3:0]          sel_q;
    logic                we_q;
    logic                ack_q;
    logic [31:0]         rdat_q;
    logic                irq_q;
    logic [31:0]         regs_q [NREGS];
    logic [CHANNELS-1:0] status_q;
    logic [CHANNELS-1:0] mask_q;

    logic                commit;
    logic                ch_hit;
    logic                g_status;
    logic                g_mask;
    logic                g_id;
    logic [IW-1:0]       idx;
    logic [31:0]         bmask;
    logic [31:0]         rd_mux;
    logic [CHANNELS-1:0] clear;
    logic                unused_adr;

    assign unused_adr = ^{wb_adr_i[31:14], wb_adr_i[1:0]};

    // Channel word index equals (ch << REGS_LOG2) + reg, so the low bits address the flat array.
    assign commit   = (state_q == S_ACK);
    assign ch_hit   = !adr_q[11] && (int'({21'b0, adr_q[10:0]}) < NREGS);
    assign g_status = adr_q[11] && (adr_q[10:0] == 11'd0);
    assign g_mask   = adr_q[11] && (adr_q[10:0] == 11'd1);
    assign g_id     = adr_q[11] && (adr_q[10:0] == 11'd2);
    assign idx      = adr_q[IW-1:0];
    assign bmask    = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
    assign clear    = (commit && we_q && g_status) ? (dat_q[CHANNELS-1:0] & bmask[CHANNELS-1:0])
                                                   : '0;

    always_comb begin
        rd_mux = '0;
        if (ch_hit)        rd_mux = regs_q[idx];
        else if (g_status) rd_mux[CHANNELS-1:0] = status_q;
        else if (g_mask)   rd_mux[CHANNELS-1:0] = mask_q;
        else if (g_id)     rd_mux = {ID_VALUE[31:16], CH8, NR8};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (wb_cyc_i && wb_stb_i && !ack_q) begin
                        adr_q   <= wb_adr_i[13:2];
                        dat_q   <= wb_dat_i;
                        sel_q   <= wb_sel_i;
                        we_q    <= wb_we_i;
                        cnt_q   <= WS4;
                        state_q <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (!wb_cyc_i)           state_q <= S_IDLE;
                    else if (cnt_q == 4'd1)  state_q <= S_ACK;
                end
                S_ACK: begin
                    // Commit edge: ack rises and read data captures the pre-write value.
                    ack_q   <= 1'b1;
                    rdat_q  <= rd_mux;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (commit && we_q && ch_hit) begin
            regs_q[idx] <= (regs_q[idx] & ~bmask) | (dat_q & bmask);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= dump_strobe | (status_q & ~clear);
            if (commit && we_q && g_mask)
                mask_q <= (mask_q & ~bmask[CHANNELS-1:0]) | (dat_q[CHANNELS-1:0] & bmask[CHANNELS-1:0]);
            irq_q <= |(status_q & mask_q);
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign ch_regs[g*32 +: 32] = regs_q[g];
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = rdat_q;
    assign accum_int = irq_q;
endmodule

// File: tb/tb_namuru_wb_csr.sv
// tb/tb_namuru_wb_csr.sv - scoreboard bench for namuru_wb_csr
// Two instances: zero wait states (u0) and three wait states (u3).
`timescale 1ns/1ps
module tb_namuru_wb_csr;
    localparam int CH = 12;
    localparam int RW = CH * 8 * 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   adr = '0, dat = '0;
    logic [3:0]    sel = '0;
    logic          we = 1'b0;
    logic          cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
    logic [CH-1:0] dump = '0;
    logic [31:0]   rd0, rd3;
    logic          ack0, ack3, irq0, irq3;
    logic [RW-1:0] regs0, regs3;

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   exp_q[$];
    logic          irq_at_ack;

    always #5 clk = ~clk;

    namuru_wb_csr #(.CHANNELS(CH), .REGS_LOG2(3), .WAIT_STATES(0), .ID_VALUE(32'h4E410000)) u0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(rd0),
        .wb_sel_i(sel), .wb_stb_i(stb0), .wb_cyc_i(cyc0), .wb_we_i(we), .wb_ack_o(ack0),
        .dump_strobe(dump), .ch_regs(regs0), .accum_int(irq0));

    namuru_wb_csr #(.CHANNELS(CH), .REGS_LOG2(3), .WAIT_STATES(3), .ID_VALUE(32'h4E410000)) u3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(rd3),
        .wb_sel_i(sel), .wb_stb_i(stb3), .wb_cyc_i(cyc3), .wb_we_i(we), .wb_ack_o(ack3),
        .dump_strobe(dump), .ch_regs(regs3), .accum_int(irq3));

    function automatic logic [31:0] gaddr(input int off);
        return (32'h800 | 32'(off)) << 2;
    endfunction

    function automatic logic [31:0] caddr(input int c, input int r);
        return 32'((c << 3) | r) << 2;
    endfunction

    function automatic logic ack_of(input int d);
        return (d == 0) ? ack0 : ack3;
    endfunction

    function automatic logic [31:0] rd_of(input int d);
        return (d == 0) ? rd0 : rd3;
    endfunction

    // pulse_n > 0 raises dump_strobe[2] for the cycle following the pulse_n-th negedge of the wait loop.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic [31:0] exp_rd, input int exp_lat,
                        input int pulse_n, input string name);
        int          n;
        logic        got;
        logic [31:0] e;
        exp_q.push_back(exp_rd);
        @(negedge clk);
        adr = a; dat = wd; sel = s; we = w;
        if (d == 0) begin cyc0 = 1'b1; stb0 = 1'b1; end
        else        begin cyc3 = 1'b1; stb3 = 1'b1; end
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ack_of(d)) got = 1'b1;
            dump = (n == pulse_n) ? CH'(4) : '0;
        end
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
        irq_at_ack = (d == 0) ? irq0 : irq3;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s ack_timeout: ack=0 after %0d cycles, required ack", name, n);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (rd_of(d) !== e) begin
                errors++;
                $display("FAIL %s data: got %h want %h", name, rd_of(d), e);
            end
            checks++;
            if (n - 1 !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, n - 1, exp_lat);
            end
            @(negedge clk);
            dump = '0;
            checks++;
            if (ack_of(d) !== 1'b0 || rd_of(d) !== 32'h0) begin
                errors++;
                $display("FAIL %s after_ack: ack=%b dat=%h want ack=0 dat=0", name, ack_of(d), rd_of(d));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack0 !== 1'b0 || rd0 !== 32'h0 || irq0 !== 1'b0 || regs0 !== '0) begin
            errors++;
            $display("FAIL reset_u0: ack=%b dat=%h irq=%b regs_nonzero=%b want all 0", ack0, rd0, irq0, |regs0);
        end
        checks++;
        if (ack3 !== 1'b0 || rd3 !== 32'h0 || irq3 !== 1'b0 || regs3 !== '0) begin
            errors++;
            $display("FAIL reset_u3: ack=%b dat=%h irq=%b regs_nonzero=%b want all 0", ack3, rd3, irq3, |regs3);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_id();
        xfer(0, 1'b0, gaddr(2), 32'h0, 4'hF, 32'h4E410C08, 1, 0, "id_u0");
        xfer(3, 1'b0, gaddr(2), 32'h0, 4'hF, 32'h4E410C08, 4, 0, "id_u3");
    endtask

    task automatic test_byte_lanes();
        xfer(0, 1'b1, caddr(3, 5), 32'hDEADBEEF, 4'b0101, 32'h0, 1, 0, "ch3r5_write");
        checks++;
        if (regs0[29*32 +: 32] !== 32'h00AD00EF) begin
            errors++;
            $display("FAIL ch3r5_slice: got %h want %h", regs0[29*32 +: 32], 32'h00AD00EF);
        end
        xfer(0, 1'b0, caddr(3, 5), 32'h0, 4'hF, 32'h00AD00EF, 1, 0, "ch3r5_read");
        xfer(0, 1'b1, caddr(3, 5), 32'h11223344, 4'b1000, 32'h00AD00EF, 1, 0, "ch3r5_lane3");
        xfer(0, 1'b1, caddr(3, 5), 32'hFFFFFFFF, 4'b0000, 32'h11AD00EF, 1, 0, "ch3r5_sel0");
        xfer(0, 1'b0, caddr(3, 5), 32'h0, 4'hF, 32'h11AD00EF, 1, 0, "ch3r5_reread");
        xfer(0, 1'b1, caddr(11, 7), 32'hCAFEF00D, 4'hF, 32'h0, 1, 0, "ch11r7_write");
        checks++;
        if (regs0[95*32 +: 32] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL ch11r7_slice: got %h want %h", regs0[95*32 +: 32], 32'hCAFEF00D);
        end
    endtask

    task automatic test_wait_abort();
        bit seen;
        xfer(3, 1'b1, gaddr(1), 32'h00000FFF, 4'hF, 32'h0, 4, 0, "mask_u3_write");
        @(negedge clk);
        adr = gaddr(1); dat = 32'h0; sel = 4'hF; we = 1'b1; cyc3 = 1'b1; stb3 = 1'b1;
        repeat (2) @(negedge clk);
        cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack3) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_ack: ack seen=1 want 0");
        end
        xfer(3, 1'b0, gaddr(1), 32'h0, 4'hF, 32'h00000FFF, 4, 0, "mask_u3_kept");
    endtask

    task automatic test_interrupt();
        xfer(0, 1'b1, gaddr(1), 32'h00000004, 4'b0001, 32'h0, 1, 0, "mask_u0_write");
        @(negedge clk);
        dump = CH'(4);
        @(negedge clk);
        dump = '0;
        checks++;
        if (irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: got %b want 0", irq0);
        end
        @(negedge clk);
        checks++;
        if (irq0 !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: got %b want 1", irq0);
        end
        xfer(0, 1'b0, gaddr(0), 32'h0, 4'hF, 32'h00000004, 1, 0, "status_read");
        xfer(0, 1'b1, gaddr(0), 32'h00000004, 4'hF, 32'h00000004, 1, 0, "status_w1c");
        checks++;
        if (irq_at_ack !== 1'b1 || irq0 !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: at_ack=%b after=%b want 1 then 0", irq_at_ack, irq0);
        end
        xfer(0, 1'b0, gaddr(0), 32'h0, 4'hF, 32'h0, 1, 0, "status_cleared");
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        dump = CH'(4);
        @(negedge clk);
        dump = '0;
        repeat (2) @(negedge clk);
        xfer(0, 1'b1, gaddr(0), 32'h00000004, 4'hF, 32'h00000004, 1, 1, "w1c_vs_set");
        checks++;
        if (irq_at_ack !== 1'b1 || irq0 !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_irq: at_ack=%b after=%b want 1 and 1", irq_at_ack, irq0);
        end
        xfer(0, 1'b0, gaddr(0), 32'h0, 4'hF, 32'h00000004, 1, 0, "set_wins_status");
        xfer(0, 1'b1, gaddr(0), 32'h00000004, 4'b0001, 32'h00000004, 1, 0, "final_clear");
    endtask

    task automatic test_out_of_range();
        xfer(0, 1'b1, caddr(12, 0), 32'h12345678, 4'hF, 32'h0, 1, 0, "oor_ch_write");
        xfer(0, 1'b0, caddr(12, 0), 32'h0, 4'hF, 32'h0, 1, 0, "oor_ch_read");
        xfer(0, 1'b1, gaddr(7), 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0, "oor_g7_write");
        xfer(0, 1'b0, gaddr(7), 32'h0, 4'hF, 32'h0, 1, 0, "oor_g7_read");
        xfer(0, 1'b0, caddr(3, 5), 32'h0, 4'hF, 32'h11AD00EF, 1, 0, "oor_no_alias");
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        @(negedge clk);
        adr = gaddr(2); sel = 4'hF; we = 1'b0; cyc3 = 1'b1; stb3 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack3 !== 1'b0 || rd3 !== 32'h0 || irq3 !== 1'b0 || irq0 !== 1'b0 ||
            regs3 !== '0 || regs0 !== '0) begin
            errors++;
            $display("FAIL reset_in_wait: ack=%b dat=%h irq3=%b irq0=%b regs0_nz=%b want all 0",
                     ack3, rd3, irq3, irq0, |regs0);
        end
        cyc3 = 1'b0; stb3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack3) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_ack_suppressed: ack seen=1 want 0");
        end
        xfer(3, 1'b0, gaddr(1), 32'h0, 4'hF, 32'h0, 4, 0, "mask_after_reset");
    endtask

    initial begin
        test_reset();
        test_id();
        test_byte_lanes();
        test_wait_abort();
        test_interrupt();
        test_set_wins();
        test_out_of_range();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
